// File: rtl/ddr_axi_wr_master.sv
// ddr_axi_wr_master
//   Drains 256-bit words from the upstream store FIFO and writes them to DDR
//   as AXI4 INCR bursts, one outstanding burst at a time.
//
//   Clock/reset : axi_clk, rst (asynchronous, active low)
//   Upstream    : ddr_trig (FIFO holds a burst), alen (beats-1), rdata_fifo,
//                 trig_en (data valid), wready_rx (read request)
//   AXI AW      : m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid, m_awready
//   AXI W       : m_wdata, m_wstrb, m_wlast, m_wvalid, m_wready
//   AXI B       : m_bresp, m_bvalid, m_bready
//   Status      : burst_done (pulse), err_flag (sticky), busy
//
//   Build option: define DDR_ADDR_WRAP_EN to keep bursts inside the circular
//   region [BASE_ADDR, BASE_ADDR+REGION_BYTES) and off 4 KB boundaries.
//   Without it the address simply increments modulo 2^ADDR_W.
module ddr_axi_wr_master #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0]  REGION_BYTES = ADDR_W'(32'h0100_0000),
  parameter int                 BUF_DEPTH    = 4
) (
  input  logic              axi_clk,
  input  logic              rst,
  input  logic              ddr_trig,
  input  logic [7:0]        alen,
  input  logic [255:0]      rdata_fifo,
  input  logic              trig_en,
  output logic              wready_rx,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [255:0]      m_wdata,
  output logic [31:0]       m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              burst_done,
  output logic              err_flag,
  output logic              busy
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int USED_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          len_reg;
  logic [7:0]          awlen_reg;
  logic [ADDR_W-1:0]   awaddr_reg;
  logic [8:0]          req_cnt_reg;
  logic [8:0]          beat_cnt_reg;
  logic [CNT_W-1:0]    inflight_reg;
  logic [CNT_W-1:0]    occ_reg;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic                err_reg, done_reg;

  // Small skid buffer; head is read combinationally so m_wdata tracks the
  // pop pointer without an extra pipeline stage.
  logic [255:0]        buf_mem [BUF_DEPTH];

  logic                in_w, can_req, starved, w_hs, last_beat, b_hs;
  logic                push_ok, push, pop, drop, full, infl_dec;
  logic [USED_W-1:0]   used_slots;
  logic [ADDR_W-1:0]   sum_addr, next_addr, start_addr;
  logic                unused_bits;

  function automatic logic [ADDR_W-1:0] burst_bytes(input logic [7:0] l);
    return ADDR_W'({1'b0, l} + 9'd1) << 5;
  endfunction

  assign in_w       = (state_reg == S_W);
  assign used_slots = USED_W'(occ_reg) + USED_W'(inflight_reg);
  // Keep two slots of headroom: a request may take up to two cycles to return.
  assign can_req    = (used_slots + USED_W'(2)) <= USED_W'(BUF_DEPTH);
  assign wready_rx  = in_w && (req_cnt_reg <= {1'b0, len_reg}) && can_req;

  // A dropped beat would otherwise leave the burst short forever; once every
  // request has returned and the buffer is dry, the stale head entry is
  // replayed to finish the burst.
  assign starved    = in_w && (occ_reg == '0) && (inflight_reg == '0) &&
                      (req_cnt_reg > {1'b0, len_reg});

  assign m_wvalid   = in_w && ((occ_reg != '0) || starved);
  assign m_wdata    = buf_mem[rd_ptr_reg];
  assign m_wlast    = m_wvalid && (beat_cnt_reg == {1'b0, len_reg});
  assign w_hs       = m_wvalid && m_wready;
  assign last_beat  = w_hs && (beat_cnt_reg == {1'b0, len_reg});
  assign b_hs       = (state_reg == S_B) && m_bvalid;

  assign full       = (occ_reg == CNT_W'(BUF_DEPTH));
  assign pop        = w_hs && (occ_reg != '0);
  assign push_ok    = trig_en && in_w;
  assign push       = push_ok && (!full || pop);
  assign drop       = push_ok && full && !pop;
  assign infl_dec   = push_ok && (inflight_reg != '0);

  assign m_awaddr   = awaddr_reg;
  assign m_awlen    = awlen_reg;
  assign m_awsize   = 3'b101;
  assign m_awburst  = 2'b01;
  assign m_wstrb    = '1;
  assign m_awvalid  = (state_reg == S_AW);
  assign m_bready   = (state_reg == S_B);
  assign busy       = (state_reg != S_IDLE);
  assign burst_done = done_reg;
  assign err_flag   = err_reg;

  // Only SLVERR/DECERR (bit 1) matter; the region size is consumed only by
  // the wrap build.
  assign unused_bits = m_bresp[0] ^ (^REGION_BYTES);

  always_comb begin
    sum_addr   = awaddr_reg + burst_bytes(len_reg);
    next_addr  = sum_addr;
    start_addr = awaddr_reg;
`ifdef DDR_ADDR_WRAP_EN
    if ((sum_addr - BASE_ADDR) >= REGION_BYTES) next_addr = BASE_ADDR;
    // Burst length is only known at start, so the 4 KB and region-end
    // checks are applied when the next burst is launched.
    if ((14'(awaddr_reg[11:0]) + 14'(burst_bytes(alen))) > 14'd4096)
      start_addr = (awaddr_reg | ADDR_W'(12'hFFF)) + ADDR_W'(1);
    if ((start_addr - BASE_ADDR + burst_bytes(alen)) > REGION_BYTES)
      start_addr = BASE_ADDR;
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ddr_trig)  state_next = S_AW;
      S_AW:    if (m_awready) state_next = S_W;
      S_W:     if (last_beat) state_next = S_B;
      S_B:     if (m_bvalid)  state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      awlen_reg    <= '0;
      awaddr_reg   <= BASE_ADDR;
      req_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      inflight_reg <= '0;
      occ_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= b_hs;
      if (drop || (trig_en && !in_w) || (b_hs && m_bresp[1]))
        err_reg <= 1'b1;

      if ((state_reg == S_IDLE) && ddr_trig) begin
        len_reg    <= alen;
        awlen_reg  <= alen;
        awaddr_reg <= start_addr;
      end

      if (b_hs) begin
        awaddr_reg   <= next_addr;
        req_cnt_reg  <= '0;
        beat_cnt_reg <= '0;
        inflight_reg <= '0;
        occ_reg      <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
      end else begin
        req_cnt_reg  <= req_cnt_reg + {8'd0, wready_rx};
        beat_cnt_reg <= beat_cnt_reg + {8'd0, w_hs};
        inflight_reg <= inflight_reg + CNT_W'(wready_rx) - CNT_W'(infl_dec);
        occ_reg      <= occ_reg + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) buf_mem[wr_ptr_reg] <= rdata_fifo;
  end

endmodule
